// File: rtl/arcade_input_mapper_if.sv
// arcade_input_mapper_if: bundles the hps_io inputs and per-player control outputs of the mapper
interface arcade_input_mapper_if #(
    parameter int NP = 2,
    parameter int NB = 2
);
    logic [10:0]      ps2_key;
    logic [16*NP-1:0] joy;
    logic [1:0]       rot;
    logic [NP-1:0]    af_sel;
    logic [4*NP-1:0]  o_dir;
    logic [NB*NP-1:0] o_btn;
    logic [NP-1:0]    o_start;
    logic [NP-1:0]    o_coin;
    logic             o_test;
    modport master (output ps2_key, joy, rot, af_sel, input o_dir, o_btn, o_start, o_coin, o_test);
    modport slave  (input ps2_key, joy, rot, af_sel, output o_dir, o_btn, o_start, o_coin, o_test);
endinterface

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and joysticks into rotated, SOCD-cleaned player controls
// with coin stretching; optional AUTOFIRE_EN macro adds per-player fire0 autofire.
module arcade_input_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 2,
    parameter int COIN_PULSE  = 600000,
    parameter int AF_PERIOD   = 1200000
) (
    input logic clk_sys,
    input logic RESET,
    arcade_input_mapper_if.slave bus
);
    localparam int NP = NUM_PLAYERS;
    localparam int NB = NUM_BUTTONS;
    localparam int CW = $clog2(COIN_PULSE + 1);

    // Key state per keyboard player, laid out like a joystick word: dir[3:0], fire[7:4], start 8, coin 9
    logic       r_tog;
    logic [9:0] r_key [2];
    logic       r_test;
    logic       r_test_o;
    logic       w_evt;
    logic       w_hit;
    logic       w_ok;
    logic       w_pl;
    logic       w_is_test;
    logic [3:0] w_bit;

    assign w_evt = bus.ps2_key[10] ^ r_tog;

    always_comb begin
        w_hit = 1'b1;
        w_pl = 1'b0;
        w_bit = 4'd0;
        w_is_test = 1'b0;
        casez (bus.ps2_key[8:0])
            9'b?_0111_0101: w_bit = 4'd3;
            9'b?_0111_0010: w_bit = 4'd2;
            9'b?_0110_1011: w_bit = 4'd1;
            9'b?_0111_0100: w_bit = 4'd0;
            9'h014: w_bit = 4'd4;
            9'h011: w_bit = 4'd5;
            9'h029: w_bit = 4'd6;
            9'h012: w_bit = 4'd7;
            9'h016: w_bit = 4'd8;
            9'h02E: w_bit = 4'd9;
            9'h02D: begin w_pl = 1'b1; w_bit = 4'd3; end
            9'h02B: begin w_pl = 1'b1; w_bit = 4'd2; end
            9'h023: begin w_pl = 1'b1; w_bit = 4'd1; end
            9'h034: begin w_pl = 1'b1; w_bit = 4'd0; end
            9'h01C: begin w_pl = 1'b1; w_bit = 4'd4; end
            9'h01B: begin w_pl = 1'b1; w_bit = 4'd5; end
            9'h015: begin w_pl = 1'b1; w_bit = 4'd6; end
            9'h01D: begin w_pl = 1'b1; w_bit = 4'd7; end
            9'h01E: begin w_pl = 1'b1; w_bit = 4'd8; end
            9'h036: begin w_pl = 1'b1; w_bit = 4'd9; end
            9'h02C: w_is_test = 1'b1;
            default: w_hit = 1'b0;
        endcase
        w_ok = w_hit && !w_is_test && (int'(w_pl) < NP) &&
               (w_bit < 4'd4 || w_bit > 4'd7 || int'(w_bit) - 4 < NB);
    end

    always_ff @(posedge clk_sys) begin
        r_tog <= bus.ps2_key[10];
        r_test_o <= RESET ? 1'b0 : r_test;
        if (RESET) begin
            r_key <= '{default: '0};
            r_test <= 1'b0;
        end else if (w_evt) begin
            if (w_ok) r_key[w_pl][w_bit] <= bus.ps2_key[9];
            if (w_is_test) r_test <= bus.ps2_key[9];
        end
    end

    assign bus.o_test = r_test_o;

    for (genvar p = 0; p < NP; p++) begin : g_pl
        logic [3:0]    w_kd;
        logic [NB-1:0] w_kf;
        logic          w_ks;
        logic          w_kc;
        if (p < 2) begin : g_key
            assign w_kd = r_key[p][3:0];
            assign w_kf = r_key[p][4 +: NB];
            assign w_ks = r_key[p][8];
            assign w_kc = r_key[p][9];
        end else begin : g_nokey
            assign w_kd = '0;
            assign w_kf = '0;
            assign w_ks = 1'b0;
            assign w_kc = 1'b0;
        end
        logic [3:0]    w_raw;
        logic [3:0]    w_rot;
        logic [NB-1:0] w_fire;
        logic          w_start;
        logic          w_coin;
        logic          w_mask;
        assign w_raw   = w_kd | bus.joy[16*p +: 4];
        assign w_fire  = w_kf | bus.joy[16*p+4 +: NB];
        assign w_start = w_ks | bus.joy[16*p+4+NB];
        assign w_coin  = w_kc | bus.joy[16*p+5+NB];
        assign w_rot = bus.rot == 2'd1 ? {w_raw[1], w_raw[0], w_raw[2], w_raw[3]} :
                       bus.rot == 2'd2 ? {w_raw[2], w_raw[3], w_raw[0], w_raw[1]} :
                       bus.rot == 2'd3 ? {w_raw[0], w_raw[1], w_raw[3], w_raw[2]} : w_raw;
`ifdef AUTOFIRE_EN
        localparam int AW = $clog2(AF_PERIOD + 1);
        logic          r_f0p;
        logic          r_ph;
        logic [AW-1:0] r_afc;
        logic          w_rise;
        logic          w_ph;
        logic          w_end;
        logic [AW-1:0] w_c;
        // A fresh fire0 press restarts the wave at the start of its high phase
        assign w_rise = w_fire[0] & ~r_f0p;
        assign w_ph   = w_rise | r_ph;
        assign w_c    = w_rise ? '0 : r_afc;
        assign w_end  = w_c == AW'(AF_PERIOD - 1);
        assign w_mask = ~bus.af_sel[p] | w_ph;
        always_ff @(posedge clk_sys) begin
            if (RESET) begin
                r_f0p <= 1'b0;
                r_ph <= 1'b1;
                r_afc <= '0;
            end else begin
                r_f0p <= w_fire[0];
                r_ph <= w_end ? ~w_ph : w_ph;
                r_afc <= w_end ? '0 : w_c + 1'b1;
            end
        end
`else
        assign w_mask = 1'b1;
`endif
        logic [3:0]    r_dir;
        logic [NB-1:0] r_btn;
        logic          r_start;
        logic          r_cprev;
        logic [CW-1:0] r_cnt;
        always_ff @(posedge clk_sys) begin
            if (RESET) begin
                r_dir <= '0;
                r_btn <= '0;
                r_start <= 1'b0;
                r_cprev <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_dir <= {w_rot[3] & ~w_rot[2], w_rot[2] & ~w_rot[3], w_rot[1] & ~w_rot[0], w_rot[0] & ~w_rot[1]};
                r_btn <= w_fire & ~NB'({~w_mask});
                r_start <= w_start;
                r_cprev <= w_coin;
                r_cnt <= (r_cnt != '0) ? r_cnt - 1'b1 : (w_coin & ~r_cprev) ? CW'(COIN_PULSE) : '0;
            end
        end
        assign bus.o_dir[4*p +: 4]   = r_dir;
        assign bus.o_btn[NB*p +: NB] = r_btn;
        assign bus.o_start[p]        = r_start;
        assign bus.o_coin[p]         = |r_cnt;
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of a 4-player/4-button mapper and a default-sized one
module tb_arcade_input_mapper;
    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic [10:0] ps2 = '0;
    logic [63:0] joy = '0;
    logic [1:0]  rot = '0;
    logic [3:0]  af_sel = 4'b0001;
    int          n_cmp = 0;
    int          n_err = 0;
    int          hi;
    logic [15:0] pat_p1;
    logic [15:0] pat_p2;
    logic [15:0] exp_p1;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper_if #(.NP(4), .NB(4)) if1 ();
    arcade_input_mapper_if #(.NP(2), .NB(2)) if2 ();
    assign if1.ps2_key = ps2;
    assign if1.joy     = joy;
    assign if1.rot     = rot;
    assign if1.af_sel  = af_sel;
    assign if2.ps2_key = ps2;
    assign if2.joy     = joy[31:0];
    assign if2.rot     = rot;
    assign if2.af_sel  = af_sel[1:0];

    arcade_input_mapper #(.NUM_PLAYERS(4), .NUM_BUTTONS(4), .COIN_PULSE(8), .AF_PERIOD(4))
        dut1 (.clk_sys(clk_sys), .RESET(RESET), .bus(if1));
    arcade_input_mapper #(.NUM_PLAYERS(2), .NUM_BUTTONS(2), .COIN_PULSE(8), .AF_PERIOD(4))
        dut2 (.clk_sys(clk_sys), .RESET(RESET), .bus(if2));

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic [8:0] code, input logic pr);
        ps2 = {~ps2[10], pr, code};
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        step(2);
        RESET = 1'b0;
        chk("rst_dir", if1.o_dir, 16'h0);
        chk("rst_btn", if1.o_btn, 16'h0);
        chk("rst_misc", {if1.o_start, if1.o_coin, if1.o_test}, 9'h0);
        key(9'h075, 1'b1);
        step(1);
        chk("key_lat1", if1.o_dir, 16'h0);
        step(1);
        chk("key_lat2", if1.o_dir, 16'h0008);
        key(9'h075, 1'b0);
        step(1);
        chk("rel_lat1", if1.o_dir, 16'h0008);
        step(1);
        chk("rel_lat2", if1.o_dir, 16'h0);
        joy[1] = 1'b1;
        rot = 2'd1;
        step(1);
        chk("rot1", if1.o_dir, 16'h0008);
        rot = 2'd3;
        step(1);
        chk("rot3", if1.o_dir, 16'h0004);
        rot = 2'd2;
        step(1);
        chk("rot2", if1.o_dir, 16'h0001);
        rot = 2'd0;
        step(1);
        chk("rot0", if1.o_dir, 16'h0002);
        joy = '0;
        key(9'h075, 1'b1);
        joy[2] = 1'b1;
        step(2);
        chk("socd_ud", if1.o_dir, 16'h0);
        joy = 64'h3;
        step(1);
        chk("socd_lr", if1.o_dir, 16'h0008);
        key(9'h075, 1'b0);
        joy = '0;
        step(2);
        key(9'h0AA, 1'b1);
        step(2);
        chk("unmapped", {if1.o_dir, if1.o_btn, if1.o_start, if1.o_test}, 37'h0);
        key(9'h02C, 1'b1);
        step(2);
        chk("test_on", if1.o_test, 1'b1);
        key(9'h02C, 1'b0);
        step(2);
        chk("test_off", if1.o_test, 1'b0);
        joy[55] = 1'b1;
        step(1);
        chk("p4_fire3", if1.o_btn, 16'h8000);
        joy = '0;
        key(9'h01D, 1'b1);
        step(2);
        chk("p2_fire3", if1.o_btn, 16'h0080);
        chk("p2_fire3_nb2", if2.o_btn, 4'h0);
        key(9'h01D, 1'b0);
        step(1);
        key(9'h029, 1'b1);
        step(2);
        chk("p1_fire2", if1.o_btn, 16'h0004);
        chk("p1_fire2_nb2", if2.o_btn, 4'h0);
        key(9'h029, 1'b0);
        step(1);
        key(9'h02D, 1'b1);
        step(2);
        chk("p2_up", if1.o_dir, 16'h0080);
        key(9'h02D, 1'b0);
        step(1);
        key(9'h016, 1'b1);
        step(2);
        chk("start1", if1.o_start, 4'h1);
        chk("start1_nb2", if2.o_start, 2'h1);
        key(9'h016, 1'b0);
        step(2);
        key(9'h036, 1'b1);
        step(2);
        chk("p2_keycoin", if1.o_coin, 4'h2);
        key(9'h036, 1'b0);
        step(10);
        chk("p2_keycoin_end", if1.o_coin, 4'h0);
        joy[9] = 1'b1;
        step(1);
        chk("coin_first", if1.o_coin, 4'h1);
        hi = 1;
        for (int i = 0; i < 19; i++) begin
            step(1);
            hi += int'(if1.o_coin[0]);
        end
        chk("coin_held_len", hi, 8);
        joy[9] = 1'b0;
        step(4);
        joy[9] = 1'b1;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            hi += int'(if1.o_coin[0]);
        end
        chk("coin_second_len", hi, 8);
        joy[9] = 1'b0;
        step(2);
        joy[9] = 1'b1;
        step(3);
        chk("coin_mid", if1.o_coin, 4'h1);
        RESET = 1'b1;
        joy[9] = 1'b0;
        step(1);
        chk("coin_reset", if1.o_coin, 4'h0);
        RESET = 1'b0;
        step(3);
        chk("coin_after_reset", if1.o_coin, 4'h0);
        key(9'h075, 1'b1);
        step(2);
        chk("hold_pre_rst", if1.o_dir, 16'h0008);
        RESET = 1'b1;
        step(1);
        chk("hold_in_rst", if1.o_dir, 16'h0);
        RESET = 1'b0;
        step(2);
        chk("hold_post_rst", if1.o_dir, 16'h0);
        key(9'h075, 1'b0);
        step(2);
        joy[4] = 1'b1;
        joy[20] = 1'b1;
        pat_p1 = '0;
        pat_p2 = '0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            pat_p1 = {pat_p1[14:0], if1.o_btn[0]};
            pat_p2 = {pat_p2[14:0], if1.o_btn[4]};
        end
`ifdef AUTOFIRE_EN
        exp_p1 = 16'b1111000011110000;
`else
        exp_p1 = 16'hFFFF;
`endif
        chk("af_p1", pat_p1, exp_p1);
        chk("af_p2", pat_p2, 16'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
